// File: rtl/qspi_flash_responder.sv
// Quad-SPI flash target for Fast Read Quad I/O (EBh): SCLK/CS are oversampled on ACLK,
// and 32-bit words are served from a preloadable internal array.
module qspi_flash_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DUMMY_CLKS  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic                           sclk,
  input  logic                           cs_n,
  input  logic [3:0]                     io_in,
  output logic [3:0]                     io_out,
  output logic [3:0]                     io_oe,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
  input  logic [31:0]                    wr_data,
  output logic                           busy,
  output logic                           bad_cmd
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned ADDR_NIBS = ADDR_W / 4;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_IGNORE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            shift_q, shift_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [1:0]             lo2_q, lo2_d;
  logic [AW-1:0]          widx_q, widx_d;
  logic                   drive_en_q, drive_en_d;
  logic                   bad_cmd_q, bad_cmd_d;

  logic                   sclk_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_fall;
  logic [7:0]             instr;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;

  logic [31:0]            mem_q [DEPTH_WORDS];
  logic [31:0]            prefetch_q;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign instr     = {shift_q[6:0], io_in[0]};

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    lo2_d       = lo2_q;
    widx_d      = widx_q;
    drive_en_d  = drive_en_q;
    bad_cmd_d   = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = widx_q;

    if (cs_s) begin
      state_d    = S_IDLE;
      drive_en_d = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = CNT_W'(7);
            idx_d   = '0;
            lo2_d   = '0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            shift_d = {shift_q[30:0], io_in[0]};
            if (cnt_q == '0) begin
              if (instr == 8'hEB) begin
                state_d = S_ADDR;
                cnt_d   = CNT_W'(ADDR_NIBS - 1);
              end else begin
                state_d   = S_IGNORE;
                bad_cmd_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        S_ADDR: begin
          // Accumulate only the word index (address >> 2): the low two bits of each
          // nibble are held back one step so byte-offset bits never enter idx_q.
          if (sclk_rise) begin
            idx_d = AW'({idx_q, lo2_q, io_in[3:2]});
            lo2_d = io_in[1:0];
            if (cnt_q == '0) begin
              state_d = S_MODE;
              cnt_d   = CNT_W'(1);
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        S_MODE: begin
          if (sclk_rise) begin
            shift_d = {shift_q[27:0], io_in};
            if (cnt_q == '0) begin
              state_d = S_DUMMY;
              cnt_d   = CNT_W'(DUMMY_CLKS - 1);
              rd_en   = 1'b1;
              rd_addr = idx_q;
              widx_d  = idx_q;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        S_DUMMY: begin
          if (sclk_rise) begin
            if (cnt_q == '0) begin
              state_d = S_DATA;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        S_DATA: begin
          // cnt_q == 0 means the shift register is exhausted: load the prefetched
          // word and immediately prefetch its successor.
          if (sclk_fall) begin
            if (cnt_q == '0) begin
              shift_d    = prefetch_q;
              drive_en_d = 1'b1;
              cnt_d      = CNT_W'(7);
              rd_en      = 1'b1;
              rd_addr    = widx_q + AW'(1);
              widx_d     = widx_q + AW'(1);
            end else begin
              shift_d = {shift_q[27:0], 4'h0};
              cnt_d   = cnt_q - 1'b1;
            end
          end
        end
        S_IGNORE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      lo2_q       <= '0;
      widx_q      <= '0;
      drive_en_q  <= 1'b0;
      bad_cmd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      lo2_q       <= lo2_d;
      widx_q      <= widx_d;
      drive_en_q  <= drive_en_d;
      bad_cmd_q   <= bad_cmd_d;
    end
  end

  // Array is not reset; a same-cycle write to the word being prefetched is forwarded.
  always_ff @(posedge ACLK) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) prefetch_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
  end

  assign io_out  = shift_q[31:28];
  assign io_oe   = {4{drive_en_q & ~cs_n}};
  assign busy    = (state_q != S_IDLE);
  assign bad_cmd = bad_cmd_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Scoreboard bench for qspi_flash_responder: a behavioural QSPI initiator pushes expected
// nibbles from a word-array model; a monitor pops them at each SCLK rise while driven.
module tb_qspi_flash_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned DUMMY = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned H     = 8;   // ACLK cycles per SCLK half-period

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic [3:0]  io_in = 4'h0;
  logic [3:0]  io_out;
  logic [3:0]  io_oe;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic        bad_cmd;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned nib_seen = 0;
  int unsigned bad_seen = 0;
  int unsigned exp_bad = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [3:0]  exp_q [$];

  qspi_flash_responder #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W(24),
    .DUMMY_CLKS(DUMMY),
    .SYNC_STAGES(SYNC)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .sclk(sclk),
    .cs_n(cs_n),
    .io_in(io_in),
    .io_out(io_out),
    .io_oe(io_oe),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .bad_cmd(bad_cmd)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every SCLK rise with the bus driven consumes one expected nibble.
  always @(posedge sclk) begin
    if (io_oe !== 4'h0) begin
      n_cmp++;
      if (io_oe !== 4'hF) begin
        n_err++;
        $display("FAIL io_oe_partial: got %h want f", io_oe);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_drive: got nibble %h want bus released", io_out);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        nib_seen++;
        if (io_out !== e) begin
          n_err++;
          $display("FAIL data_nibble #%0d: got %h want %h", nib_seen, io_out, e);
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (bad_cmd === 1'b1) bad_seen++;
    if (cs_n === 1'b1) begin
      n_cmp++;
      if (io_oe !== 4'h0) begin
        n_err++;
        $display("FAIL oe_while_cs_high: got %h want 0", io_oe);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic write_word(input int unsigned idx, input logic [31:0] d);
    @(negedge ACLK);
    wr_en   = 1'b1;
    wr_addr = 10'(idx);
    wr_data = d;
    @(negedge ACLK);
    wr_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic clk_cycle(input logic [3:0] d);
    io_in = d;
    repeat (H) @(negedge ACLK);
    sclk = 1'b1;
    repeat (H) @(negedge ACLK);
    sclk = 1'b0;
  endtask

  task automatic finish_xfer();
    check("busy_before_cs_rise", {31'b0, busy}, 32'd1);
    repeat (H) @(negedge ACLK);
    cs_n = 1'b1;
    #1 check("oe_released_on_cs", {28'b0, io_oe}, 32'h0);
    repeat (SYNC + 1) @(posedge ACLK);
    #1 check("busy_after_cs_rise", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge ACLK);
    check("leftover_nibbles", exp_q.size(), 32'd0);
    check("bad_cmd_pulses", bad_seen, exp_bad);
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [23:0] addr,
                         input int unsigned ndata, input bit close);
    cs_n = 1'b0;
    repeat (H) @(negedge ACLK);
    if (cmd == 8'hEB) begin
      for (int unsigned i = 0; i < ndata; i++) begin
        logic [31:0] w;
        w = ref_mem[((int'(addr) >> 2) + i / 8) % DEPTH];
        exp_q.push_back(4'(w >> (28 - 4 * (i % 8))));
      end
    end
    for (int i = 0; i < 8; i++) clk_cycle({3'b000, cmd[7-i]});
    if (cmd == 8'hEB) begin
      for (int i = 0; i < 6; i++) clk_cycle(4'(addr >> (20 - 4 * i)));
      clk_cycle(4'($urandom));
      clk_cycle(4'($urandom));
      repeat (DUMMY) clk_cycle(4'h0);
      repeat (ndata) clk_cycle(4'h0);
    end else begin
      exp_bad++;
      repeat (40) clk_cycle(4'($urandom));
    end
    if (close) finish_xfer();
  endtask

  initial begin
    int unsigned base;
    #3;
    check("rst_io_oe", {28'b0, io_oe}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_bad_cmd", {31'b0, bad_cmd}, 32'd0);
    check("rst_io_out", {28'b0, io_out}, 32'h0);
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;

    for (int unsigned i = 0; i < DEPTH; i++) write_word(i, $urandom);

    // Basic read
    write_word(32'h40, 32'hBABABABE);
    do_read(8'hEB, 24'h000100, 8, 1'b1);

    // Streaming wrap at the top of the array
    write_word(DEPTH - 1, 32'h11223344);
    write_word(0, 32'hDEADBEEF);
    do_read(8'hEB, 24'((DEPTH - 1) * 4), 16, 1'b1);

    // Bad command, then a valid read
    do_read(8'h03, 24'h0, 0, 1'b1);
    do_read(8'hEB, 24'h000100, 8, 1'b1);

    // Abort after 3 data nibbles, then a fresh read from 0
    do_read(8'hEB, 24'h000000, 3, 1'b1);
    do_read(8'hEB, 24'h000000, 8, 1'b1);

    // Write to the in-flight word mid-word
    write_word(32'h55, 32'h0BADF00D);
    base = nib_seen;
    fork
      do_read(8'hEB, 24'h55 * 4, 8, 1'b1);
      begin
        for (int t = 0; t < 4000 && nib_seen < base + 3; t++) @(negedge ACLK);
        check("midword_wait", {31'b0, nib_seen >= base + 3}, 32'd1);
        write_word(32'h55, 32'hC0FFEE42);
      end
    join
    do_read(8'hEB, 24'h55 * 4, 8, 1'b1);

    // SCLK glitches with CS high
    for (int i = 0; i < 10; i++) begin
      io_in = 4'($urandom);
      repeat (2) @(negedge ACLK);
      sclk = ~sclk;
    end
    sclk = 1'b0;
    repeat (6) @(negedge ACLK);
    check("glitch_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-DATA
    do_read(8'hEB, 24'h000200, 5, 1'b0);
    #3 ARESETn = 1'b0;
    #1;
    check("areset_io_oe", {28'b0, io_oe}, 32'h0);
    check("areset_busy", {31'b0, busy}, 32'd0);
    cs_n = 1'b1;
    repeat (4) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (4) @(negedge ACLK);
    do_read(8'hEB, 24'h000200, 8, 1'b1);

    // Randomized transactions with interleaved preloads
    for (int k = 0; k < 8; k++) begin
      logic [7:0] cmd;
      repeat ($urandom_range(1, 4)) write_word($urandom_range(0, DEPTH - 1), $urandom);
      cmd = 8'hEB;
      if ($urandom_range(0, 4) == 0) begin
        cmd = 8'($urandom);
        if (cmd == 8'hEB) cmd = 8'h6B;
      end
      do_read(cmd, 24'($urandom), $urandom_range(1, 20), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
